// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display blocks: segment
// encodings (active-low {g,f,e,d,c,b,a}) and the scanner state type.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-low seven-segment pattern, purely combinational.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // table lookup of the segment pattern for the nibble
    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg7_scanner.sv
// Time-multiplexed seven-segment scanner. The divided scan clock is
// synchronised and edge-detected into a one-cycle tick; each tick starts a
// blank gap followed by the next digit. The value is latched whenever the
// scan wraps back to digit 0, so a frame never mixes two values.
module seg7_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    scan_clk,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES - 1);

    logic [SYNC_STAGES-1:0]  sync_r;
    logic                    edge_r;
    logic                    tick_s;

    state_e                  state_r, state_s;
    logic [IDX_W-1:0]        idx_r, idx_s;
    logic [CNT_W-1:0]        cnt_r, cnt_s;
    logic [4*NUM_DIGITS-1:0] sh_val_r, sh_val_s;
    logic [NUM_DIGITS-1:0]   sh_dp_r, sh_dp_s;

    logic [NUM_DIGITS-1:0]   an_r, an_s;
    logic [6:0]              seg_r, seg_s;
    logic                    dp_r, dp_s;

    logic [4*NUM_DIGITS-1:0] shifted_s;
    logic [3:0]              nibble_s;
    logic [6:0]              dec_seg_s;
    logic [NUM_DIGITS-1:0]   sel_s;
    logic                    lz_hit_s;
    logic                    dp_bit_s;

    // synchroniser chain and edge-detect flop for the asynchronous scan clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
            edge_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], scan_clk};
            edge_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign tick_s = sync_r[SYNC_STAGES-1] & ~edge_r;

    // next-state logic: en drop beats the blank countdown, which beats a tick
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        cnt_s    = cnt_r;
        sh_val_s = sh_val_r;
        sh_dp_s  = sh_dp_r;
        if (!en) begin
            state_s = IDLE;
            idx_s   = IDX_LAST;
        end else begin
            case (state_r)
                IDLE: begin
                    if (tick_s) begin
                        state_s = BLANK;
                        cnt_s   = CNT_LOAD;
                    end else begin
                        state_s = IDLE;
                    end
                end
                BLANK: begin
                    if (cnt_r == '0) begin
                        state_s = DRIVE;
                        if (idx_r == IDX_LAST) begin
                            idx_s    = '0;
                            sh_val_s = value;
                            sh_dp_s  = dp_mask;
                        end else begin
                            idx_s = idx_r + IDX_W'(1);
                        end
                    end else begin
                        cnt_s = cnt_r - CNT_W'(1);
                    end
                end
                DRIVE: begin
                    if (tick_s) begin
                        state_s = BLANK;
                        cnt_s   = CNT_LOAD;
                    end else begin
                        state_s = DRIVE;
                    end
                end
                default: begin
                    state_s = IDLE;
                    idx_s   = IDX_LAST;
                end
            endcase
        end
    end

    assign shifted_s = sh_val_s >> {idx_s, 2'b00};
    assign nibble_s  = shifted_s[3:0];

    seg7_decode u_decode (
        .nibble (nibble_s),
        .seg    (dec_seg_s)
    );

    // output values for the upcoming cycle, so the first DRIVE cycle is live
    always_comb begin
        sel_s        = '0;
        sel_s[idx_s] = 1'b1;
        dp_bit_s     = sh_dp_s[idx_s];
        lz_hit_s     = lz_blank && (idx_s != '0) && (shifted_s == '0);
        an_s         = '1;
        seg_s        = SEG_OFF;
        dp_s         = 1'b1;
        if (state_s == DRIVE) begin
            if (lz_hit_s) begin
                if (dp_bit_s) begin
                    an_s = ~sel_s;
                    dp_s = 1'b0;
                end else begin
                    an_s = '1;
                    dp_s = 1'b1;
                end
            end else begin
                an_s  = ~sel_s;
                seg_s = dec_seg_s;
                dp_s  = ~dp_bit_s;
            end
        end else begin
            an_s  = '1;
            seg_s = SEG_OFF;
            dp_s  = 1'b1;
        end
    end

    // state, shadow and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            idx_r    <= IDX_LAST;
            cnt_r    <= '0;
            sh_val_r <= '0;
            sh_dp_r  <= '0;
            an_r     <= '1;
            seg_r    <= SEG_OFF;
            dp_r     <= 1'b1;
        end else begin
            state_r  <= state_s;
            idx_r    <= idx_s;
            cnt_r    <= cnt_s;
            sh_val_r <= sh_val_s;
            sh_dp_r  <= sh_dp_s;
            an_r     <= an_s;
            seg_r    <= seg_s;
            dp_r     <= dp_s;
        end
    end

    assign an  = an_r;
    assign seg = seg_r;
    assign dp  = dp_r;

endmodule

// File: tb/tb_seg7_scanner.sv
// Self-checking bench for seg7_scanner. Two instances share the data inputs:
// instance a (4-cycle gap) gets a variable scan period, instance b (8-cycle
// gap, scan period 6) sees ticks arriving inside the gap. A frame-level
// reference model predicts the outputs every cycle.
module tb_seg7_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_a = 1'b0;
    logic        scan_b = 1'b0;
    logic        en = 1'b1;
    logic [15:0] value = 16'h1234;
    logic [3:0]  dp_mask = 4'h0;
    logic        lz_blank = 1'b0;
    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;

    int total = 0;
    int bad = 0;

    seg7_scanner #(.NUM_DIGITS(4), .SYNC_STAGES(2), .BLANK_CYCLES(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .scan_clk(scan_a), .en(en), .value(value),
        .dp_mask(dp_mask), .lz_blank(lz_blank), .an(an_a), .seg(seg_a), .dp(dp_a)
    );

    seg7_scanner #(.NUM_DIGITS(4), .SYNC_STAGES(2), .BLANK_CYCLES(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .scan_clk(scan_b), .en(en), .value(value),
        .dp_mask(dp_mask), .lz_blank(lz_blank), .an(an_b), .seg(seg_b), .dp(dp_b)
    );

    always #5 clk = ~clk;

    // reference: segment table, and per-instance display state
    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int          gap_len [2] = '{4, 8};
    int          m_mode [2];      // 0 dark, 1 in gap, 2 showing a digit
    int          m_digit [2];
    int          m_drive_at [2];  // edge number at which the gap ends
    logic [15:0] m_val [2];
    logic [3:0]  m_dp [2];
    logic [3:0]  m_hist [2];      // scan_clk samples, bit n = n edges ago
    int          edge_cnt = 0;
    int          rise_edge = 0;
    logic        prev_a = 1'b0;
    int          cnt_a = 0;
    int          cnt_b = 0;
    int          half_a = 20;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k]  = 0;
            m_digit[k] = 3;
            m_val[k]   = 16'h0;
            m_dp[k]    = 4'h0;
            m_hist[k]  = 4'h0;
        end
    endtask

    task automatic model_step();
        logic tick;
        for (int k = 0; k < 2; k++) begin
            m_hist[k] = {m_hist[k][2:0], (k == 0) ? scan_a : scan_b};
            // a rise seen two samples ago becomes this edge's tick
            tick = m_hist[k][2] & ~m_hist[k][3];
            if (!en) begin
                m_mode[k]  = 0;
                m_digit[k] = 3;
            end else if (m_mode[k] == 1) begin
                if (edge_cnt == m_drive_at[k]) begin
                    m_digit[k] = (m_digit[k] + 1) % 4;
                    if (m_digit[k] == 0) begin
                        m_val[k] = value;
                        m_dp[k]  = dp_mask;
                    end
                    m_mode[k] = 2;
                end
            end else if (tick) begin
                m_mode[k]     = 1;
                m_drive_at[k] = edge_cnt + gap_len[k];
            end
        end
    endtask

    function automatic logic [11:0] exp_out(input int k);
        int          d;
        logic [15:0] upper;
        logic [3:0]  anon;
        if (m_mode[k] != 2) return {4'hF, 7'h7F, 1'b1};
        d     = m_digit[k];
        upper = m_val[k] >> (4 * d);
        anon  = ~(4'b0001 << d);
        if (lz_blank && d > 0 && upper == 16'h0) begin
            if (m_dp[k][d]) return {anon, 7'h7F, 1'b0};
            return {4'hF, 7'h7F, 1'b1};
        end
        return {anon, seg_tab[upper[3:0]], ~m_dp[k][d]};
    endfunction

    // one clock: move scan clocks at negedge, step model at posedge, compare after
    task automatic step();
        @(negedge clk);
        cnt_a++;
        if (cnt_a >= half_a) begin
            scan_a = ~scan_a;
            cnt_a  = 0;
        end
        cnt_b++;
        if (cnt_b >= 3) begin
            scan_b = ~scan_b;
            cnt_b  = 0;
        end
        @(posedge clk);
        edge_cnt++;
        if (scan_a && !prev_a) rise_edge = edge_cnt;
        prev_a = scan_a;
        if (rst_n) model_step();
        #1;
        if (rst_n) begin
            chk("cycle_a", int'({an_a, seg_a, dp_a}), int'(exp_out(0)));
            chk("cycle_b", int'({an_b, seg_b, dp_b}), int'(exp_out(1)));
        end
    endtask

    task automatic wait_an(input logic [3:0] target, input string tag);
        for (int i = 0; i < 400; i++) begin
            step();
            if (an_a == target) break;
        end
        chk(tag, int'(an_a), int'(target));
    endtask

    logic [3:0] lat_an [6] = '{4'b1011, 4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] lat_seg [6] = '{7'h24, 7'h79, 7'h21, 7'h46, 7'h03, 7'h08};

    initial begin
        model_reset();
        #12;
        chk("rst_an", int'(an_a), 32'hF);
        chk("rst_seg", int'(seg_a), 32'h7F);
        chk("rst_dp", int'(dp_a), 32'h1);
        chk("rst_an_b", int'(an_b), 32'hF);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // first drive latency and normal 1234 frame
        wait_an(4'b1110, "first_an");
        chk("first_latency", edge_cnt - rise_edge + 1, 7);
        chk("d0_seg", int'(seg_a), 32'h19);
        wait_an(4'b1101, "d1_an");
        chk("d1_seg", int'(seg_a), 32'h30);

        // value changes mid-frame: rest of frame keeps the latched value
        value = 16'hABCD;
        for (int i = 0; i < 6; i++) begin
            wait_an(lat_an[i], "latch_an");
            chk("latch_seg", int'(seg_a), int'(lat_seg[i]));
        end

        // leading-zero blanking, latched at the next wrap
        lz_blank = 1'b1;
        value    = 16'h0070;
        dp_mask  = 4'b0100;
        wait_an(4'b1110, "lz_d0_an");
        chk("lz_d0_seg", int'(seg_a), 32'h40);
        wait_an(4'b1101, "lz_d1_an");
        chk("lz_d1_seg", int'(seg_a), 32'h78);
        wait_an(4'b1011, "lz_d2_an");
        chk("lz_d2_seg", int'(seg_a), 32'h7F);
        chk("lz_d2_dp", int'(dp_a), 32'h0);

        // asynchronous reset while digit 1 is driven
        wait_an(4'b1101, "pre_rst_an");
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", int'(an_a), 32'hF);
        chk("async_seg", int'(seg_a), 32'h7F);
        chk("async_dp", int'(dp_a), 32'h1);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_an(4'b1110, "post_rst_an");
        chk("post_rst_seg", int'(seg_a), 32'h40);

        // en drop during digit 2, then restart from digit 0
        wait_an(4'b1011, "pre_en_an");
        en = 1'b0;
        step();
        chk("en_off_an", int'(an_a), 32'hF);
        en = 1'b1;
        wait_an(4'b1110, "en_back_an");

        // randomized run against the model
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) < 3) value = 16'($urandom);
            if ($urandom_range(0, 99) < 3) dp_mask = 4'($urandom);
            if ($urandom_range(0, 99) < 2) lz_blank = ~lz_blank;
            if ($urandom_range(0, 99) < 1) half_a = $urandom_range(2, 25);
            if (en && $urandom_range(0, 99) < 2) en = 1'b0;
            else if (!en && $urandom_range(0, 99) < 20) en = 1'b1;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
